// File: rtl/jk_q_pulse_monitor_if.sv
// Measurement handshake between the pulse monitor and its consumer.
// The master side presents one measurement at a time with valid/ready flow control.
interface jk_q_pulse_monitor_if #(
  parameter int unsigned CNT_W = 16
);
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_period;
  logic [CNT_W-1:0] m_high;
  logic             m_sat;

  modport master (
    output m_valid,
    output m_period,
    output m_high,
    output m_sat,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_period,
    input  m_high,
    input  m_sat,
    output m_ready
  );
endinterface

// File: rtl/jk_q_pulse_monitor.sv
// Observes a JK flip-flop q output: edge pulses, toggle count, and per-period
// high-time/period measurements delivered through a one-deep valid/ready buffer.
module jk_q_pulse_monitor #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned EVT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 q_in,
  input  logic                 enable,
  input  logic                 clr,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [EVT_W-1:0]     toggle_cnt,
  output logic                 overflow,
  jk_q_pulse_monitor_if.master m
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             q_d;
  logic             primed;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] per_inc_c;
  logic [CNT_W-1:0] high_inc_c;
  logic             rise_c;
  logic             fall_c;
  logic             emit_c;

  // Edges are only trusted once q_d holds a sample taken while enabled.
  assign rise_c = primed & enable &  q_in & ~q_d;
  assign fall_c = primed & enable & ~q_in &  q_d;

  assign per_inc_c  = (per_q  == CNT_MAX) ? per_q  : per_q  + CNT_ONE;
  assign high_inc_c = (high_q == CNT_MAX) ? high_q : high_q + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      per_q   <= '0;
      high_q  <= '0;
      lat_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      high_q  <= high_d;
      lat_q   <= lat_d;
      sat_q   <= sat_d;
    end
  end

  // Measurement FSM: IDLE waits for a first rise, HIGH/LOW track the current period.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    high_d  = high_q;
    lat_d   = lat_q;
    sat_d   = sat_q;
    emit_c  = 1'b0;
    if (clr || !enable) begin
      state_d = IDLE;
      per_d   = '0;
      high_d  = '0;
      lat_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            state_d = HIGH;
            per_d   = CNT_ONE;
            high_d  = CNT_ONE;
            sat_d   = 1'b0;
          end
        end
        HIGH: begin
          per_d = per_inc_c;
          if (fall_c) begin
            lat_d   = high_q;
            sat_d   = sat_q | (per_inc_c == CNT_MAX);
            state_d = LOW;
          end else begin
            high_d = high_inc_c;
            sat_d  = sat_q | (per_inc_c == CNT_MAX) | (high_inc_c == CNT_MAX);
          end
        end
        LOW: begin
          if (rise_c) begin
            emit_c  = 1'b1;
            per_d   = CNT_ONE;
            high_d  = CNT_ONE;
            sat_d   = 1'b0;
            state_d = HIGH;
          end else begin
            per_d = per_inc_c;
            sat_d = sat_q | (per_inc_c == CNT_MAX);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Edge pulses, toggle count and the one-deep output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_d        <= 1'b0;
      primed     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      toggle_cnt <= '0;
      overflow   <= 1'b0;
      m.m_valid  <= 1'b0;
      m.m_period <= '0;
      m.m_high   <= '0;
      m.m_sat    <= 1'b0;
    end else begin
      q_d <= q_in;
      if (clr) begin
        primed     <= 1'b0;
        rise_pulse <= 1'b0;
        fall_pulse <= 1'b0;
        toggle_cnt <= '0;
        overflow   <= 1'b0;
        m.m_valid  <= 1'b0;
      end else begin
        primed     <= enable;
        rise_pulse <= rise_c;
        fall_pulse <= fall_c;
        if (rise_c || fall_c) begin
          toggle_cnt <= toggle_cnt + EVT_W'(1);
        end
        if (emit_c) begin
          // A held, unaccepted measurement wins; the new one is dropped.
          if (!m.m_valid || m.m_ready) begin
            m.m_valid  <= 1'b1;
            m.m_period <= per_q;
            m.m_high   <= lat_q;
            m.m_sat    <= sat_q;
          end else begin
            overflow <= 1'b1;
          end
        end else if (m.m_valid && m.m_ready) begin
          m.m_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_jk_q_pulse_monitor.sv
// Randomized and directed checks of jk_q_pulse_monitor (CNT_W=16 and CNT_W=4
// instances side by side) against a timestamp-based reference model.
module tb_jk_q_pulse_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic q_in = 1'b1;
  logic enable = 1'b1;
  logic clr = 1'b0;
  logic m_ready = 1'b1;

  logic       rp16, fp16, ovf16, rp4, fp4, ovf4;
  logic [7:0] tog16, tog4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  jk_q_pulse_monitor_if #(.CNT_W(16)) m16 ();
  jk_q_pulse_monitor_if #(.CNT_W(4))  m4 ();
  assign m16.m_ready = m_ready;
  assign m4.m_ready  = m_ready;

  jk_q_pulse_monitor #(.CNT_W(16), .EVT_W(8)) u_dut16 (
    .clk(clk), .rst(rst), .q_in(q_in), .enable(enable), .clr(clr),
    .rise_pulse(rp16), .fall_pulse(fp16), .toggle_cnt(tog16),
    .overflow(ovf16), .m(m16)
  );

  jk_q_pulse_monitor #(.CNT_W(4), .EVT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .q_in(q_in), .enable(enable), .clr(clr),
    .rise_pulse(rp4), .fall_pulse(fp4), .toggle_cnt(tog4),
    .overflow(ovf4), .m(m4)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: edges from consecutive samples, measurements from rise/fall timestamps.
  logic        mqd = 1'b0, mp = 1'b0, armed = 1'b0;
  logic        e_rise = 1'b0, e_fall = 1'b0, e_valid = 1'b0, e_ovf = 1'b0;
  logic [7:0]  e_tog = 8'd0;
  logic [31:0] e_per [2];
  logic [31:0] e_high [2];
  logic [31:0] e_sat [2];
  int unsigned cyc = 0, t_rise = 0, t_fall = 0, p = 0, h = 0;
  logic        r, f, emit;

  function automatic logic [31:0] min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  task automatic cmp_inst(input string tag, input logic rp, input logic fp, input logic [7:0] tog,
                          input logic ovf, input logic vld, input logic [31:0] per,
                          input logic [31:0] hi, input logic [31:0] sat, input int idx);
    chk({tag, "_rise_pulse"}, 32'(rp), 32'(e_rise));
    chk({tag, "_fall_pulse"}, 32'(fp), 32'(e_fall));
    chk({tag, "_toggle_cnt"}, 32'(tog), 32'(e_tog));
    chk({tag, "_overflow"}, 32'(ovf), 32'(e_ovf));
    chk({tag, "_m_valid"}, 32'(vld), 32'(e_valid));
    if (e_valid) begin
      chk({tag, "_m_period"}, per, e_per[idx]);
      chk({tag, "_m_high"}, hi, e_high[idx]);
      chk({tag, "_m_sat"}, sat, e_sat[idx]);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mp = 1'b0; armed = 1'b0; e_rise = 1'b0; e_fall = 1'b0;
      e_valid = 1'b0; e_ovf = 1'b0; e_tog = 8'd0;
      for (int i = 0; i < 2; i++) begin e_per[i] = 0; e_high[i] = 0; e_sat[i] = 0; end
    end else begin
      r = mp & enable & q_in & ~mqd;
      f = mp & enable & ~q_in & mqd;
      emit = 1'b0;
      if (clr) begin
        e_rise = 1'b0; e_fall = 1'b0; e_tog = 8'd0;
        e_valid = 1'b0; e_ovf = 1'b0; armed = 1'b0;
      end else begin
        e_rise = r; e_fall = f;
        if (r || f) e_tog = e_tog + 8'd1;
        if (!enable) armed = 1'b0;
        else if (r) begin emit = armed; armed = 1'b1; end
        if (emit) begin
          p = cyc - t_rise;
          h = t_fall - t_rise;
          if (!e_valid || m_ready) begin
            e_valid = 1'b1;
            e_per[0] = min_u(p, 65535); e_high[0] = min_u(h, 65535); e_sat[0] = 32'(p >= 65535);
            e_per[1] = min_u(p, 15);    e_high[1] = min_u(h, 15);    e_sat[1] = 32'(p >= 15);
          end else begin
            e_ovf = 1'b1;
          end
        end else if (e_valid && m_ready) begin
          e_valid = 1'b0;
        end
        if (r) t_rise = cyc;
        if (f && armed) t_fall = cyc;
      end
      mp = enable & ~clr;
    end
    mqd = rst ? 1'b0 : q_in;
    cyc++;
    #1;
    cmp_inst("d16", rp16, fp16, tog16, ovf16, m16.m_valid, 32'(m16.m_period), 32'(m16.m_high),
             32'(m16.m_sat), 0);
    cmp_inst("d4", rp4, fp4, tog4, ovf4, m4.m_valid, 32'(m4.m_period), 32'(m4.m_high),
             32'(m4.m_sat), 1);
  end

  task automatic step(input logic q, input logic en, input logic cl, input logic rdy);
    @(negedge clk);
    q_in = q; enable = en; clr = cl; m_ready = rdy;
  endtask

  task automatic pat(input int n, input int hi, input int lo, input logic rdy);
    for (int k = 0; k < n; k++) begin
      repeat (hi) step(1'b1, 1'b1, 1'b0, rdy);
      repeat (lo) step(1'b0, 1'b0 | 1'b1, 1'b0, rdy);
    end
  endtask

  // Checks the measurement visible after the emit cycle just driven.
  task automatic pin(input int unsigned p16, input int unsigned h16, input int unsigned p4,
                     input int unsigned h4, input logic s4);
    @(posedge clk); #2;
    chk("lit_m_valid", 32'(m16.m_valid), 1);
    chk("lit_period16", 32'(m16.m_period), p16);
    chk("lit_high16", 32'(m16.m_high), h16);
    chk("lit_sat16", 32'(m16.m_sat), 0);
    chk("lit_period4", 32'(m4.m_period), p4);
    chk("lit_high4", 32'(m4.m_high), h4);
    chk("lit_sat4", 32'(m4.m_sat), 32'(s4));
    chk("model_period16", e_per[0], p16);
    chk("model_period4", e_per[1], p4);
    chk("model_sat4", e_sat[1], 32'(s4));
  endtask

  logic qv;
  int   run;

  initial begin
    // Reset held with q high; releasing must not report a rise.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) step(1'b1, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("lit_no_rise_tog", 32'(tog16), 0);
    chk("lit_no_rise_valid", 32'(m16.m_valid), 0);
    chk("model_no_rise_tog", 32'(e_tog), 0);

    // Steady 3-high / 2-low with a ready consumer.
    pat(6, 3, 2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    pin(5, 3, 5, 3, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);

    // Stalled consumer: first measurement held, later ones dropped.
    pat(3, 3, 2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("lit_stall_valid", 32'(m16.m_valid), 0);
    chk("lit_stall_ovf", 32'(ovf16), 1);
    chk("model_stall_ovf", 32'(e_ovf), 1);

    // Long high phase saturates the narrow counters only.
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    pin(22, 20, 15, 15, 1'b1);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    pin(5, 3, 5, 3, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-HIGH clears outputs without waiting for a clock.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("lit_rst_tog16", 32'(tog16), 0);
    chk("lit_rst_tog4", 32'(tog4), 0);
    chk("lit_rst_ovf", 32'(ovf16), 0);
    chk("lit_rst_valid", 32'(m4.m_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    pat(3, 3, 2, 1'b1);

    // Enable dropped for one cycle in the low phase restarts measurement.
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    pat(3, 3, 2, 1'b1);

    // clr with a coincident rise while a stale measurement and overflow are pending.
    pat(4, 3, 2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("lit_clr_valid", 32'(m16.m_valid), 0);
    chk("lit_clr_ovf", 32'(ovf16), 0);
    chk("lit_clr_tog", 32'(tog4), 0);
    chk("lit_clr_rise", 32'(rp16), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1);

    // Random run lengths, enable drops, clears, resets and backpressure.
    qv = 1'b1;
    run = 0;
    repeat (3000) begin
      if (run == 0) begin
        qv = ~qv;
        run = $urandom_range(1, 22);
      end
      run--;
      @(negedge clk);
      q_in    = qv;
      enable  = ($urandom_range(0, 49) != 0);
      clr     = ($urandom_range(0, 199) == 0);
      m_ready = ($urandom_range(0, 3) != 0);
      rst     = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_q_pulse_monitor.md
Name: jk_q_pulse_monitor

Overview:
- Downstream observer for the JK flip-flop output `q`, on the same clock domain.
- Detects edges on `q` and counts toggles.
- Measures the high time and the period (rising edge to rising edge) in clock cycles.
- Delivers each completed measurement through a valid/ready output with a one-deep buffer.

Parameters:
- CNT_W, 16: width of the period and high-time counters (saturating).
- EVT_W, 8: width of the toggle counter (wraps).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- q_in  input  1  `q` from the JK flip-flop, synchronous to clk.
- enable  input  1  monitor enable.
- clr  input  1  synchronous clear; highest priority after rst.
- rise_pulse  output  1  one-cycle pulse per detected rising edge.
- fall_pulse  output  1  one-cycle pulse per detected falling edge.
- toggle_cnt  output  EVT_W  count of detected edges, modulo 2^EVT_W.
- m_valid  output  1  measurement available.
- m_ready  input  1  consumer accepts the measurement.
- m_period  output  CNT_W  cycles between consecutive rising edges.
- m_high  output  CNT_W  cycles `q` stayed high within that period.
- m_sat  output  1  a counter saturated during this measurement.
- overflow  output  1  sticky: a measurement was dropped.

Behaviour:
- Reset:
  - rst asserted → all outputs 0, state IDLE, counters 0, q_d 0, primed 0.
  - Takes effect immediately, including mid-measurement.
- Edge detection:
  - q_d is q_in registered each cycle. primed is set one cycle after rst release while enable=1.
  - rise = primed & q_in & ~q_d; fall = primed & ~q_in & q_d.
  - The first sample after rst release, or after enable 0→1, only loads q_d. No edge is reported, so q_in=1 at release is not a rise.
- rise_pulse / fall_pulse: registered, high for exactly the cycle after the detection cycle (latency 1).
- toggle_cnt: +1 on each rise or fall; wraps from all-ones to 0.
- FSM states: IDLE, HIGH, LOW.
  - IDLE, on rise → HIGH; per_cnt=1, high_cnt=1. No measurement is emitted (the first period is partial). Fall is ignored.
  - HIGH, each non-edge cycle → per_cnt+1, high_cnt+1.
  - HIGH, on fall → high_lat=high_cnt, per_cnt+1, go to LOW.
  - LOW, each non-edge cycle → per_cnt+1.
  - LOW, on rise → emit {period=per_cnt, high=high_lat, sat}; per_cnt=1, high_cnt=1, sat cleared; go to HIGH.
- Example: high 3 cycles, low 2 cycles → period 5, high 3.
- Saturation:
  - per_cnt and high_cnt stop at 2^CNT_W−1 and never wrap.
  - Reaching the limit sets the internal sat bit, which is reported as m_sat.
- Output buffer (one deep), loaded on the emit cycle; m_valid rises the following cycle:
  - m_valid=0 → load, m_valid=1.
  - m_valid=1 and m_ready=1 in the same cycle as an emit → load the new measurement, m_valid stays 1.
  - m_valid=1 and m_ready=0 during an emit → keep the old measurement, drop the new one, set overflow (sticky).
  - Handshake with no emit → m_valid=0 next cycle.
  - m_period, m_high and m_sat are stable while m_valid=1 and m_ready=0.
- enable=0:
  - FSM → IDLE; counters and primed cleared.
  - No edges, pulses or emits; toggle_cnt holds.
  - Output buffer and overflow are unaffected; a pending measurement can still be taken.
- clr=1:
  - Next cycle: toggle_cnt=0, overflow=0, m_valid=0, FSM IDLE, counters 0, primed 0.
  - clr overrides any same-cycle edge or emit.

Test Plan:
- Hold rst=1 with q_in=1, release with enable=1, keep q_in=1 for 10 cycles → rise_pulse never asserts, toggle_cnt=0, m_valid=0.
- q_in repeating 3 high / 2 low, m_ready=1 → no measurement after the 1st rise; at the 2nd and every later rise m_valid pulses with m_period=5, m_high=3, m_sat=0; toggle_cnt +2 per period; each pulse output lags its edge by 1 cycle.
- Same pattern with m_ready=0 for 3 periods → first measurement held stable, overflow=1 after the 2nd emit; then m_ready=1 for 1 cycle → m_valid=0 next cycle, overflow stays 1.
- CNT_W=4, q_in high 20 cycles then low 2, then rise → m_high=15, m_period=15, m_sat=1; next 3/2 period reports m_sat=0.
- Pulse rst for 1 cycle mid-HIGH → outputs 0 immediately; next measurement appears only after two new rises. enable=0 for 1 cycle mid-LOW → no emit at the following rise, FSM restarts from IDLE.
- m_valid=1 and overflow=1, assert clr for 1 cycle with a coincident rise → next cycle m_valid=0, overflow=0, toggle_cnt=0, no rise_pulse.
